// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider with start/done handshake
//
// Purpose: divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit
// divisor, one quotient bit per clock, using a ripple-carry adder as the trial subtractor.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset_b      in   synchronous reset, active-low
//   start        in   request, sampled only while idle
//   dividend     in   [DIVIDEND_W-1:0] captured on the accepted start
//   divisor      in   [DIVISOR_W-1:0]  captured on the accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse, results valid
//   quotient     out  [DIVIDEND_W-1:0] held until the next completion
//   remainder    out  [DIVISOR_W-1:0]  held until the next completion
//   div_by_zero  out  flag for the last completed operation
`timescale 1ns/1ps

module ripple_carry_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  logic [W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[W];
endmodule

module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  // Wide enough to hold DIVIDEND_W-1 without wrapping.
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  d_q;
  logic [DIVISOR_W:0]    r_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    diff;
  logic                  non_neg;
  logic [DIVISOR_W:0]    r_next;
  logic [DIVIDEND_W-1:0] q_next;
  logic                  last_iter;

  // Restoring keeps R < D, so the partial remainder's top bit is always zero
  // between iterations; only the low bits feed the next trial value.
  logic unused_r_msb;
  assign unused_r_msb = r_q[DIVISOR_W];

  assign trial = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};

  // trial - {0, D} as trial + ~{0, D} + 1; carry-out high means no borrow.
  ripple_carry_adder #(.W(DIVISOR_W + 1)) u_sub (
    .a     (trial),
    .b     (~{1'b0, d_q}),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (non_neg)
  );

  assign r_next    = non_neg ? diff : trial;
  assign q_next    = {q_q[DIVIDEND_W-2:0], non_neg};
  assign last_iter = (cnt_q == CNT_W'(DIVIDEND_W - 1));

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              q_q   <= dividend;
              d_q   <= divisor;
              r_q   <= '0;
              cnt_q <= '0;
            end
          end
        end
        S_RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
`timescale 1ns/1ps

module tb_seq_restoring_divider;
  logic       Clock = 1'b0;
  logic       Reset_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [7:0] res_q;
  logic [3:0] res_r;
  logic       res_z;
  int         res_busy;
  int         res_lat;
  int         res_pulses;
  bit         res_unstable;

  localparam int LAT_NORMAL = 9;
  localparam int LAT_ZERO   = 1;

  always #5 Clock = ~Clock;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .Clock       (Clock),
    .Reset_b     (Reset_b),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Called from a falling-edge time; start is seen by exactly one rising edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
  endtask

  // n counts falling edges after the accepting edge; returns one cycle after done.
  task automatic wait_result();
    logic [7:0] sq;
    logic [3:0] sr;
    logic       sz;
    sq = quotient;
    sr = remainder;
    sz = div_by_zero;
    res_busy = 0; res_lat = 0; res_pulses = 0; res_unstable = 0;
    res_q = 'x; res_r = 'x; res_z = 1'bx;
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clock);
      if (busy) res_busy++;
      if (done) begin
        res_pulses++;
        if (res_lat == 0) begin
          res_lat = n;
          res_q = quotient; res_r = remainder; res_z = div_by_zero;
        end
      end else if (res_lat == 0 && {quotient, remainder, div_by_zero} !== {sq, sr, sz}) begin
        res_unstable = 1;
      end
      if (res_lat != 0 && n == res_lat + 1) break;
    end
  endtask

  task automatic test_reset();
    Reset_b = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_ctrl busy/done got=%b exp=00", {busy, done}); end
    checks++; if ({quotient, remainder, div_by_zero} !== 13'd0) begin errors++; $display("FAIL reset_out got q=%0d r=%0d z=%b exp all 0", quotient, remainder, div_by_zero); end
    Reset_b = 1'b1;
    @(negedge Clock);
    checks++; if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin errors++; $display("FAIL reset_release got busy=%b done=%b q=%0d r=%0d z=%b exp all 0", busy, done, quotient, remainder, div_by_zero); end
  endtask

  task automatic test_basic();
    launch(8'd200, 4'd7);
    wait_result();
    checks++; if (res_lat !== LAT_NORMAL) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", res_lat, LAT_NORMAL); end
    checks++; if (res_busy !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", res_busy); end
    checks++; if (res_pulses !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", res_pulses); end
    checks++; if (res_q !== 8'h1C) begin errors++; $display("FAIL basic_quotient got=%0d exp=28", res_q); end
    checks++; if (res_r !== 4'd4) begin errors++; $display("FAIL basic_remainder got=%0d exp=4", res_r); end
    checks++; if (res_z !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", res_z); end
    checks++; if (res_unstable) begin errors++; $display("FAIL basic_hold got=changed exp=stable before done"); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
    logic [3:0] tb [4] = '{4'd1, 4'd15, 4'd9, 4'd3};
    logic [7:0] tq [4] = '{8'd255, 8'd17, 8'd0, 8'd0};
    logic [3:0] tr [4] = '{4'd0, 4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i]);
      wait_result();
      checks++; if ({res_q, res_r} !== {tq[i], tr[i]}) begin errors++; $display("FAIL b2b_result %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d", ta[i], tb[i], res_q, res_r, tq[i], tr[i]); end
      checks++; if (res_pulses !== 1 || res_lat !== LAT_NORMAL || res_busy !== 8) begin errors++; $display("FAIL b2b_timing %0d/%0d got pulses=%0d lat=%0d busy=%0d exp 1/%0d/8", ta[i], tb[i], res_pulses, res_lat, res_busy, LAT_NORMAL); end
    end
  endtask

  task automatic test_div_zero();
    launch(8'd100, 4'd0);
    wait_result();
    checks++; if (res_lat !== LAT_ZERO) begin errors++; $display("FAIL dz_latency got=%0d exp=%0d", res_lat, LAT_ZERO); end
    checks++; if (res_busy !== 0) begin errors++; $display("FAIL dz_busy got=%0d exp=0", res_busy); end
    checks++; if ({res_q, res_r, res_z} !== {8'hFF, 4'd0, 1'b1}) begin errors++; $display("FAIL dz_result got q=%0h r=%0d z=%b exp q=ff r=0 z=1", res_q, res_r, res_z); end
    checks++; if (res_pulses !== 1) begin errors++; $display("FAIL dz_pulses got=%0d exp=1", res_pulses); end
    launch(8'd9, 4'd2);
    wait_result();
    checks++; if ({res_q, res_r, res_z} !== {8'd4, 4'd1, 1'b0}) begin errors++; $display("FAIL dz_follow got q=%0d r=%0d z=%b exp q=4 r=1 z=0", res_q, res_r, res_z); end
  endtask

  task automatic test_start_ignored();
    int extra;
    launch(8'd200, 4'd7);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    @(posedge Clock);
    #1;
    start = 1'b0; dividend = 8'd77; divisor = 4'd3;
    wait_result();
    checks++; if ({res_q, res_r, res_z} !== {8'd28, 4'd4, 1'b0}) begin errors++; $display("FAIL ignore_result got q=%0d r=%0d z=%b exp q=28 r=4 z=0", res_q, res_r, res_z); end
    checks++; if (res_pulses !== 1) begin errors++; $display("FAIL ignore_pulses got=%0d exp=1", res_pulses); end
    extra = 0;
    repeat (12) begin
      @(negedge Clock);
      if (busy || done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_queue got=%0d active cycles exp=0", extra); end
  endtask

  task automatic test_reset_midrun();
    int activity;
    launch(8'd200, 4'd7);
    repeat (3) @(posedge Clock);
    #1;
    Reset_b = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    checks++; if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin errors++; $display("FAIL midrun_reset got busy=%b done=%b q=%0d r=%0d z=%b exp all 0", busy, done, quotient, remainder, div_by_zero); end
    Reset_b = 1'b1;
    activity = 0;
    repeat (12) begin
      @(negedge Clock);
      if (busy || done) activity++;
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL midrun_abandon got=%0d active cycles exp=0", activity); end
    launch(8'd13, 4'd4);
    wait_result();
    checks++; if ({res_q, res_r, res_z} !== {8'd3, 4'd1, 1'b0}) begin errors++; $display("FAIL midrun_follow got q=%0d r=%0d z=%b exp q=3 r=1 z=0", res_q, res_r, res_z); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(255, 0));
      b = 4'($urandom_range(15, 0));
      ez = (b == 0);
      eq = ez ? 8'hFF : 8'(int'(a) / int'(b));
      er = ez ? 4'd0 : 4'(int'(a) % int'(b));
      launch(a, b);
      wait_result();
      checks++; if ({res_q, res_r, res_z} !== {eq, er, ez} || res_pulses !== 1) begin errors++; $display("FAIL random %0d/%0d got q=%0d r=%0d z=%b pulses=%0d exp q=%0d r=%0d z=%b pulses=1", a, b, res_q, res_r, res_z, res_pulses, eq, er, ez); end
    end
  endtask

  task automatic test_exhaustive();
    bit ok;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_result();
        if (b == 0) begin
          ok = ({res_q, res_r, res_z} === {8'hFF, 4'd0, 1'b1}) && res_lat == LAT_ZERO;
        end else begin
          ok = (int'(res_q) * b + int'(res_r) == a) && (int'(res_r) < b) && res_z === 1'b0 && res_lat == LAT_NORMAL;
        end
        ok = ok && res_pulses == 1 && !res_unstable;
        checks++; if (!ok) begin errors++; $display("FAIL exhaustive %0d/%0d got q=%0d r=%0d z=%b lat=%0d pulses=%0d exp consistent result", a, b, res_q, res_r, res_z, res_lat, res_pulses); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
